// File: rtl/weight_bram_pkg.sv
// Shared defaults and FSM state encodings for the weight BRAM reader.
package weight_bram_pkg;

    localparam int DEF_DEPTH  = 28;
    localparam int DEF_AW     = 5;
    localparam int DEF_DW     = 16;
    localparam int DEPTH_LAST = DEF_DEPTH - 1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_READ  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_LOAD  = 2'd3;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry first-word-fall-through FIFO carrying a data word plus a last flag.
// Storage is cleared on reset so the head reads as zero until the first push.
module weight_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          valid,
    output logic [1:0]    occupancy
);

    logic [DW-1:0] mem_data [2];
    logic          mem_last [2];
    logic          wr_idx;
    logic          rd_idx;
    logic [1:0]    count;

    // Storage, pointers and occupancy update; pop is only asserted when valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_idx] <= push_data;
                mem_last[wr_idx] <= push_last;
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem_data[rd_idx];
    assign head_last = mem_last[rd_idx];
    assign valid     = (count != 2'd0);
    assign occupancy = count;

endmodule

// File: rtl/weight_bram_reader.sv
// Master-side controller for one weight BRAM: streams all words out over
// valid/ready (read pass) or writes a valid/ready word stream in (load pass).
// Optional CHECKSUM output is enabled by defining WEIGHT_READ_CHECKSUM_EN.
module weight_bram_reader
    import weight_bram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          LOAD,
    input  logic [DW-1:0] LOAD_DATA,
    input  logic          LOAD_VALID,
    output logic          LOAD_READY,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_DI,
    input  logic [DW-1:0] MEM_DO,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST,
    output logic          BUSY,
`ifdef WEIGHT_READ_CHECKSUM_EN
    output logic [DW-1:0] CHECKSUM,
`endif
    output logic          DONE
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          done_q;
    logic [1:0]    occ;
    logic          rd_issue;
    logic          wr_fire;
    logic          pop;

    // The BRAM updates DO on the negedge inside the issue cycle, so the word
    // is already on MEM_DO at the closing posedge and is pushed directly.
    // A read is therefore in flight only during its issue cycle and the
    // credit check reduces to the registered FIFO occupancy.
    assign rd_issue = (state == S_READ) && (occ < 2'd2);
    assign wr_fire  = (state == S_LOAD) && LOAD_VALID;
    assign pop      = W_VALID && W_READY;

    weight_skid_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (rd_issue),
        .push_data (MEM_DO),
        .push_last (rd_ptr == LAST_ADDR),
        .pop       (pop),
        .head_data (W_DATA),
        .head_last (W_LAST),
        .valid     (W_VALID),
        .occupancy (occ)
    );

    // Pass sequencing, address pointers and the registered DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state  <= S_READ;
                        rd_ptr <= '0;
                    end else if (LOAD) begin
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        if (rd_ptr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && W_LAST) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        if (wr_ptr == LAST_ADDR) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // BRAM port drive: write has its own state, so the two never overlap.
    always_comb begin
        MEM_EN   = rd_issue || wr_fire;
        MEM_WE   = wr_fire;
        MEM_ADDR = '0;
        MEM_DI   = '0;
        if (wr_fire) begin
            MEM_ADDR = wr_ptr;
            MEM_DI   = LOAD_DATA;
        end else if (rd_issue) begin
            MEM_ADDR = rd_ptr;
        end
    end

    assign LOAD_READY = (state == S_LOAD);
    assign BUSY       = (state != S_IDLE);
    assign DONE       = done_q;

`ifdef WEIGHT_READ_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    // Running sum of accepted beats, restarted by each accepted START.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_q <= '0;
        end else if ((state == S_IDLE) && START) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + W_DATA;
        end
    end

    assign CHECKSUM = sum_q;
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Self-checking bench for weight_bram_reader: behavioural BRAM, reference
// word array, and an expected-beat queue drained by an independent monitor.
module tb_weight_bram_reader;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          LOAD = 1'b0;
    logic [DW-1:0] LOAD_DATA = '0;
    logic          LOAD_VALID = 1'b0;
    logic          LOAD_READY;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_EN;
    logic          MEM_WE;
    logic [DW-1:0] MEM_DI;
    logic [DW-1:0] MEM_DO = '0;
    logic [DW-1:0] W_DATA;
    logic          W_VALID;
    logic          W_READY = 1'b0;
    logic          W_LAST;
    logic          BUSY;
    logic          DONE;
`ifdef WEIGHT_READ_CHECKSUM_EN
    logic [DW-1:0] CHECKSUM;
`endif

    weight_bram_reader #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LOAD      (LOAD),
        .LOAD_DATA (LOAD_DATA),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(LOAD_READY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_DI    (MEM_DI),
        .MEM_DO    (MEM_DO),
        .W_DATA    (W_DATA),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_LAST    (W_LAST),
        .BUSY      (BUSY),
`ifdef WEIGHT_READ_CHECKSUM_EN
        .CHECKSUM  (CHECKSUM),
`endif
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // Behavioural BRAM: samples and updates on the falling edge.
    logic [DW-1:0] bram [0:31];
    always @(negedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) bram[MEM_ADDR] <= MEM_DI;
            else        MEM_DO <= bram[MEM_ADDR];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW:0]   exp_q [$];

    // Monitor: every accepted beat must match the head of the expected queue,
    // and a stalled word must not change before it is accepted.
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;
    always @(negedge CLK) begin
        logic [DW:0] e;
        if (RST) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_hold_data", W_DATA, held);
                check("stall_hold_valid", W_VALID, 1);
            end
            if (W_VALID && W_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got 0x%0h expected no beat", W_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", W_DATA, e[DW-1:0]);
                    check("beat_last", W_LAST, e[DW]);
                end
            end
            stalled = W_VALID && !W_READY;
            held    = W_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input bit gaps, output int last_w, output int done_c);
        int idx;
        idx    = 0;
        last_w = -1;
        done_c = -1;
        LOAD   = 1'b1;
        for (int c = 0; c < 400; c++) begin
            LOAD_VALID = (idx < DEPTH) && (!gaps || ($urandom_range(0, 2) != 0));
            LOAD_DATA  = (idx < DEPTH) ? ref_mem[idx] : '0;
            @(negedge CLK);
            if (LOAD_VALID && LOAD_READY) begin
                idx++;
                if (idx == DEPTH) last_w = c;
            end
            if (DONE) done_c = c;
            tick();
            LOAD = 1'b0;
            if (done_c >= 0) break;
        end
        LOAD_VALID = 1'b0;
    endtask

    task automatic check_bram(input string name);
        int mism;
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (bram[i] !== ref_mem[i]) mism++;
        check(name, mism, 0);
    endtask

    // mode 0: ready always; 1: ready 1,0,0,1; 2: random; 3: low through cycle 20
    task automatic run_read(input int mode, input bit with_load, input int busy_start_at,
                            output int first_v, output int last_b, output int done_c,
                            output int beats, output int reads, output int writes,
                            output int max_out, output int snap_reads,
                            output logic [DW-1:0] snap_data);
        first_v = -1; last_b = -1; done_c = -1; beats = 0; reads = 0;
        writes = 0; max_out = 0; snap_reads = -1; snap_data = '0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), ref_mem[i]});
        START = 1'b1;
        LOAD  = with_load;
        for (int c = 0; c < 300; c++) begin
            case (mode)
                0:       W_READY = 1'b1;
                1:       W_READY = ((c % 4) == 0) || ((c % 4) == 3);
                2:       W_READY = 1'($urandom_range(0, 1));
                default: W_READY = (c > 20);
            endcase
            if (c == busy_start_at) START = 1'b1;
            @(negedge CLK);
            if (MEM_EN && !MEM_WE) reads++;
            if (MEM_EN && MEM_WE) writes++;
            if (W_VALID && first_v < 0) first_v = c;
            if (W_VALID && W_READY) begin
                beats++;
                if (W_LAST) last_b = c;
            end
            if (reads - beats > max_out) max_out = reads - beats;
            if (c == 20) begin
                snap_reads = reads;
                snap_data  = W_DATA;
            end
            if (DONE) done_c = c;
            tick();
            START = 1'b0;
            LOAD  = 1'b0;
            if (done_c >= 0) break;
        end
        W_READY = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int beats, input int last_b,
                              input int done_c, input int writes, input int max_out);
        check({tag, "_done_seen"}, (done_c >= 0), 1);
        check({tag, "_beats"}, beats, DEPTH);
        check({tag, "_done_after_last"}, done_c, last_b + 1);
        check({tag, "_no_writes"}, writes, 0);
        check({tag, "_outstanding_le2"}, (max_out <= 2), 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (BUSY || W_VALID || DONE || MEM_EN) bad++;
            tick();
        end
        check({tag, "_stays_idle"}, bad, 0);
    endtask

    initial begin
        int first_v, last_b, done_c, beats, reads, writes, max_out, snap_reads;
        int last_w, nb;
        logic [DW-1:0] snap_data;
        logic [DW-1:0] sum;

        for (int i = 0; i < 32; i++) bram[i] = '0;
        repeat (3) tick();
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_w_valid", W_VALID, 0);
        check("rst_w_data", W_DATA, 0);
        check("rst_w_last", W_LAST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_mem_en", MEM_EN, 0);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_mem_di", MEM_DI, 0);
        check("rst_load_ready", LOAD_READY, 0);
        tick();

        // Load 1..28 with LOAD_VALID held high
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i + 1);
        do_load(1'b0, last_w, done_c);
        check("load1_done_after_last", done_c, last_w + 1);
        check_bram("load1_contents");

        // Full-rate read
        run_read(0, 1'b0, -1, first_v, last_b, done_c, beats, reads, writes,
                 max_out, snap_reads, snap_data);
        check("read0_first_valid", first_v, 2);
        check("read0_consecutive", last_b, first_v + DEPTH - 1);
        check_pass("read0", beats, last_b, done_c, writes, max_out);
`ifdef WEIGHT_READ_CHECKSUM_EN
        check("read0_checksum", CHECKSUM, 16'h0196);
`endif

        // Second START in the cycle right after DONE, ready pattern 1,0,0,1
        run_read(1, 1'b0, -1, first_v, last_b, done_c, beats, reads, writes,
                 max_out, snap_reads, snap_data);
        check("read1_first_valid", first_v, 2);
        check_pass("read1", beats, last_b, done_c, writes, max_out);

        // Ready held low for 20 cycles after START
        run_read(3, 1'b0, -1, first_v, last_b, done_c, beats, reads, writes,
                 max_out, snap_reads, snap_data);
        check("hold_reads_issued", snap_reads, 2);
        check("hold_w_data", snap_data, 16'h0001);
        check_pass("hold", beats, last_b, done_c, writes, max_out);

        // Reset at beat 10 of a read pass
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), ref_mem[i]});
        START = 1'b1;
        nb = 0;
        for (int c = 0; c < 300; c++) begin
            W_READY = 1'b1;
            @(negedge CLK);
            if (W_VALID && W_READY) nb++;
            tick();
            START = 1'b0;
            if (nb == 10) break;
        end
        check("rst_mid_beats", nb, 10);
        RST = 1'b1;
        W_READY = 1'b0;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_w_valid", W_VALID, 0);
        check("rst_mid_w_data", W_DATA, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_done", DONE, 0);
        check("rst_mid_mem_en", MEM_EN, 0);
        tick();
        check_idle("rst_mid", 4);

        // Replay after reset, with LOAD in the same cycle as START and a
        // START pulse while busy
        run_read(0, 1'b1, 10, first_v, last_b, done_c, beats, reads, writes,
                 max_out, snap_reads, snap_data);
        check("replay_first_valid", first_v, 2);
        check_pass("replay", beats, last_b, done_c, writes, max_out);
        check_idle("replay", 5);

        // Random contents loaded with gaps, read with random backpressure
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DW'($urandom);
            sum = sum + ref_mem[i];
        end
        do_load(1'b1, last_w, done_c);
        check("load2_done_after_last", done_c, last_w + 1);
        check_bram("load2_contents");
        for (int r = 0; r < 2; r++) begin
            run_read(2, 1'b0, 7, first_v, last_b, done_c, beats, reads, writes,
                     max_out, snap_reads, snap_data);
            check_pass("rand", beats, last_b, done_c, writes, max_out);
`ifdef WEIGHT_READ_CHECKSUM_EN
            check("rand_checksum", CHECKSUM, sum);
`endif
        end
        check_idle("final", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
